// File: rtl/kugelblitz_patch_pkg.sv
// Shared types for the kugelblitz byte-substitution patch controller.
// Entry record, frame FSM state and the default table depth.
package kugelblitz_patch_pkg;

  localparam int KG_ENTRY_COUNT = 8;
  localparam int ENTRY_OFFSET_W = 8;

  typedef struct packed {
    logic                      en;
    logic [ENTRY_OFFSET_W-1:0] offset;
    logic [7:0]                data;
  } entry_t;

  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } state_t;

endpackage

// File: rtl/kugelblitz_patch_if.sv
// Config, AXIS monitor and patch-output bundle of the patch controller.
// Stats outputs are live only when KG_PATCH_STATS_EN is defined.
interface kugelblitz_patch_if
  import kugelblitz_patch_pkg::*;
#(
  parameter int AXIS_ETH_DATA_WIDTH = 512,
  parameter int AXIS_ETH_KEEP_WIDTH = AXIS_ETH_DATA_WIDTH / 8,
  parameter int ENTRY_COUNT         = KG_ENTRY_COUNT,
  parameter int OFFSET_WIDTH        = $clog2(AXIS_ETH_KEEP_WIDTH),
  parameter int COUNT_WIDTH         = 32,
  parameter int INDEX_WIDTH         = (ENTRY_COUNT > 1) ? $clog2(ENTRY_COUNT) : 1
) ();

  logic                           cfg_wr_valid;
  logic [INDEX_WIDTH-1:0]         cfg_wr_index;
  logic [OFFSET_WIDTH-1:0]        cfg_wr_offset;
  logic [7:0]                     cfg_wr_data;
  logic                           cfg_wr_enable;
  logic                           cfg_clear;
  logic                           cfg_commit;
  logic                           cfg_commit_pending;
  logic                           cfg_commit_done;
  logic                           mon_tvalid;
  logic                           mon_tready;
  logic                           mon_tlast;
  logic                           patch_first_beat;
  logic [AXIS_ETH_KEEP_WIDTH-1:0] patch_mask;
  logic [AXIS_ETH_DATA_WIDTH-1:0] patch_data;
  logic [COUNT_WIDTH-1:0]         stat_frames;
  logic [COUNT_WIDTH-1:0]         stat_commits;

  modport master (
    output cfg_wr_valid, cfg_wr_index, cfg_wr_offset,
    output cfg_wr_data, cfg_wr_enable, cfg_clear, cfg_commit,
    output mon_tvalid, mon_tready, mon_tlast,
    input  cfg_commit_pending, cfg_commit_done,
    input  patch_first_beat, patch_mask, patch_data,
    input  stat_frames, stat_commits
  );

  modport slave (
    input  cfg_wr_valid, cfg_wr_index, cfg_wr_offset,
    input  cfg_wr_data, cfg_wr_enable, cfg_clear, cfg_commit,
    input  mon_tvalid, mon_tready, mon_tlast,
    output cfg_commit_pending, cfg_commit_done,
    output patch_first_beat, patch_mask, patch_data,
    output stat_frames, stat_commits
  );

endinterface

// File: rtl/kugelblitz_patch_decode.sv
// Combinational entry table -> per-byte mask/data.
// Lowest-index enabled entry wins when offsets collide.
module kugelblitz_patch_decode
  import kugelblitz_patch_pkg::*;
#(
  parameter int KEEP_WIDTH  = 64,
  parameter int ENTRY_COUNT = KG_ENTRY_COUNT
) (
  input  entry_t                  entries [ENTRY_COUNT],
  output logic [KEEP_WIDTH-1:0]   mask,
  output logic [KEEP_WIDTH*8-1:0] data
);

  always_comb begin
    mask = '0;
    data = '0;
    for (int b = 0; b < KEEP_WIDTH; b++) begin
      // scan high to low so the lowest index is written last
      for (int i = ENTRY_COUNT - 1; i >= 0; i--) begin
        if (entries[i].en &&
            entries[i].offset == ENTRY_OFFSET_W'(b)) begin
          mask[b]         = 1'b1;
          data[b*8 +: 8]  = entries[i].data;
        end
      end
    end
  end

endmodule

// File: rtl/kugelblitz_patch_ctrl.sv
// Per-port patch controller: shadow table, frame-boundary commit, first-beat FSM.
// Define KG_PATCH_STATS_EN to build the frame/commit counters.
module kugelblitz_patch_ctrl
  import kugelblitz_patch_pkg::*;
#(
  parameter int AXIS_ETH_DATA_WIDTH = 512,
  parameter int AXIS_ETH_KEEP_WIDTH = AXIS_ETH_DATA_WIDTH / 8,
  parameter int ENTRY_COUNT         = KG_ENTRY_COUNT,
  parameter int OFFSET_WIDTH        = $clog2(AXIS_ETH_KEEP_WIDTH),
  parameter int COUNT_WIDTH         = 32
) (
  input logic               clk,
  input logic               rst,
  kugelblitz_patch_if.slave bus
);

  state_t state_q;
  state_t state_d;

  entry_t shadow_q [ENTRY_COUNT];
  entry_t shadow_d [ENTRY_COUNT];

  logic [AXIS_ETH_KEEP_WIDTH-1:0] mask_q;
  logic [AXIS_ETH_DATA_WIDTH-1:0] data_q;
  logic [AXIS_ETH_KEEP_WIDTH-1:0] dec_mask;
  logic [AXIS_ETH_DATA_WIDTH-1:0] dec_data;

  logic                    pending_q;
  logic                    done_q;
  logic                    hs;
  logic                    hs_last;
  logic                    commit_fire;
  logic [OFFSET_WIDTH-1:0] wr_off;

  assign hs      = bus.mon_tvalid & bus.mon_tready;
  assign hs_last = hs & bus.mon_tlast;
  assign wr_off  = bus.cfg_wr_offset;

  // idle with no beat offered, or the last beat of a frame leaving
  assign commit_fire = pending_q &
                       ((state_q == IDLE && !bus.mon_tvalid) | hs_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (hs && !bus.mon_tlast) state_d = IN_FRAME;
      IN_FRAME: if (hs_last)              state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    shadow_d = shadow_q;
    if (bus.cfg_clear) begin
      for (int i = 0; i < ENTRY_COUNT; i++) shadow_d[i].en = 1'b0;
    end
    if (bus.cfg_wr_valid) begin
      shadow_d[bus.cfg_wr_index].en     = bus.cfg_wr_enable;
      shadow_d[bus.cfg_wr_index].offset = ENTRY_OFFSET_W'(wr_off);
      shadow_d[bus.cfg_wr_index].data   = bus.cfg_wr_data;
    end
  end

  // decoding the next shadow forwards same-cycle writes into a commit
  kugelblitz_patch_decode #(
    .KEEP_WIDTH  (AXIS_ETH_KEEP_WIDTH),
    .ENTRY_COUNT (ENTRY_COUNT)
  ) u_decode (
    .entries (shadow_d),
    .mask    (dec_mask),
    .data    (dec_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRY_COUNT; i++) shadow_q[i] <= '0;
      mask_q    <= '0;
      data_q    <= '0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      done_q   <= commit_fire;
      if (commit_fire) begin
        mask_q    <= dec_mask;
        data_q    <= dec_data;
        pending_q <= 1'b0;
      end else if (bus.cfg_commit) begin
        pending_q <= 1'b1;
      end
    end
  end

  assign bus.cfg_commit_pending = pending_q;
  assign bus.cfg_commit_done    = done_q;
  assign bus.patch_first_beat   = (state_q == IDLE);
  assign bus.patch_mask         = mask_q;
  assign bus.patch_data         = data_q;

`ifdef KG_PATCH_STATS_EN
  logic [COUNT_WIDTH-1:0] frames_q;
  logic [COUNT_WIDTH-1:0] commits_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frames_q  <= '0;
      commits_q <= '0;
    end else begin
      if (hs_last)     frames_q  <= frames_q + 1'b1;
      if (commit_fire) commits_q <= commits_q + 1'b1;
    end
  end

  assign bus.stat_frames  = frames_q;
  assign bus.stat_commits = commits_q;
`else
  assign bus.stat_frames  = COUNT_WIDTH'(0);
  assign bus.stat_commits = COUNT_WIDTH'(0);
`endif

endmodule

// File: tb/tb_kugelblitz_patch_ctrl.sv
// Directed bench for kugelblitz_patch_ctrl: vector table plus corner sequences.
// Stats expectations follow KG_PATCH_STATS_EN.
module tb_kugelblitz_patch_ctrl;
  import kugelblitz_patch_pkg::*;

  localparam int NV = 29;

  typedef struct {
    logic        wv;
    logic [2:0]  idx;
    logic [5:0]  off;
    logic [7:0]  dat;
    logic        en;
    logic        clr;
    logic        cmt;
    logic        tv;
    logic        tr;
    logic        tl;
    logic        e_pend;
    logic        e_done;
    logic        e_first;
    logic [63:0] e_mask;
    int          e_byte;
    logic [7:0]  e_bval;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;
  vec_t vt [NV];

  always #5 clk = ~clk;

  kugelblitz_patch_if #(
    .AXIS_ETH_DATA_WIDTH (512),
    .ENTRY_COUNT         (8),
    .COUNT_WIDTH         (32)
  ) bus ();

  kugelblitz_patch_ctrl #(
    .AXIS_ETH_DATA_WIDTH (512),
    .ENTRY_COUNT         (8),
    .COUNT_WIDTH         (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic vec_t mk(
    input logic wv, input logic [2:0] idx, input logic [5:0] off,
    input logic [7:0] dat, input logic en, input logic clr,
    input logic cmt, input logic tv, input logic tr, input logic tl,
    input logic e_pend, input logic e_done, input logic e_first,
    input logic [63:0] e_mask, input int e_byte, input logic [7:0] e_bval);
    vec_t v;
    v.wv = wv; v.idx = idx; v.off = off; v.dat = dat; v.en = en;
    v.clr = clr; v.cmt = cmt; v.tv = tv; v.tr = tr; v.tl = tl;
    v.e_pend = e_pend; v.e_done = e_done; v.e_first = e_first;
    v.e_mask = e_mask; v.e_byte = e_byte; v.e_bval = e_bval;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    bus.cfg_wr_valid  = 1'b0;
    bus.cfg_wr_index  = '0;
    bus.cfg_wr_offset = '0;
    bus.cfg_wr_data   = '0;
    bus.cfg_wr_enable = 1'b0;
    bus.cfg_clear     = 1'b0;
    bus.cfg_commit    = 1'b0;
    bus.mon_tvalid    = 1'b0;
    bus.mon_tready    = 1'b0;
    bus.mon_tlast     = 1'b0;
  endtask

  task automatic beat(input logic tl, input logic exp_first,
                      input string nm);
    chk(nm, 64'(bus.patch_first_beat), 64'(exp_first));
    bus.mon_tvalid = 1'b1;
    bus.mon_tready = 1'b1;
    bus.mon_tlast  = tl;
    @(negedge clk);
    idle_in();
  endtask

  initial begin
    // basic commit
    vt[0]  = mk(1,0,12,8'h5A,1, 0,0,0,0,0, 0,0,1,64'h0,12,8'h00);
    vt[1]  = mk(0,0,0,0,0, 0,1,0,0,0, 1,0,1,64'h0,12,8'h00);
    vt[2]  = mk(0,0,0,0,0, 0,0,0,0,0, 0,1,1,64'h1000,12,8'h5A);
    vt[3]  = mk(0,0,0,0,0, 0,0,0,0,0, 0,0,1,64'h1000,12,8'h5A);
    // deferred commit in a 3-beat frame, write lands after the request
    vt[4]  = mk(0,0,0,0,0, 0,0,1,1,0, 0,0,0,64'h1000,12,8'h5A);
    vt[5]  = mk(0,0,0,0,0, 0,1,1,1,0, 1,0,0,64'h1000,12,8'h5A);
    vt[6]  = mk(1,1,20,8'h33,1, 0,0,0,0,0, 1,0,0,64'h1000,20,8'h00);
    vt[7]  = mk(0,0,0,0,0, 0,0,1,1,1, 0,1,1,64'h101000,20,8'h33);
    vt[8]  = mk(0,0,0,0,0, 0,0,1,1,0, 0,0,0,64'h101000,12,8'h5A);
    vt[9]  = mk(0,0,0,0,0, 0,0,1,1,1, 0,0,1,64'h101000,12,8'h5A);
    // backpressure on an idle first beat holds the active table
    vt[10] = mk(1,0,3,8'h44,1, 0,0,0,0,0, 0,0,1,64'h101000,3,8'h00);
    vt[11] = mk(0,0,0,0,0, 0,1,1,0,0, 1,0,1,64'h101000,3,8'h00);
    for (int i = 12; i <= 16; i++)
      vt[i] = mk(0,0,0,0,0, 0,0,1,0,0, 1,0,1,64'h101000,3,8'h00);
    vt[17] = mk(0,0,0,0,0, 0,0,1,1,0, 1,0,0,64'h101000,3,8'h00);
    vt[18] = mk(0,0,0,0,0, 0,0,1,1,1, 0,1,1,64'h100008,3,8'h44);
    // priority, with entry2 forwarded in the commit cycle
    vt[19] = mk(1,5,7,8'h22,1, 0,0,0,0,0, 0,0,1,64'h100008,7,8'h00);
    vt[20] = mk(0,0,0,0,0, 0,1,0,0,0, 1,0,1,64'h100008,7,8'h00);
    vt[21] = mk(1,2,7,8'h11,1, 0,0,0,0,0, 0,1,1,64'h100088,7,8'h11);
    // second commit while pending is absorbed
    vt[22] = mk(0,0,0,0,0, 0,1,0,0,0, 1,0,1,64'h100088,7,8'h11);
    vt[23] = mk(0,0,0,0,0, 0,1,0,0,0, 0,1,1,64'h100088,7,8'h11);
    vt[24] = mk(0,0,0,0,0, 0,0,0,0,0, 0,0,1,64'h100088,7,8'h11);
    // clear plus write in one cycle
    vt[25] = mk(1,1,0,8'hFF,1, 1,0,0,0,0, 0,0,1,64'h100088,0,8'h00);
    vt[26] = mk(0,0,0,0,0, 0,1,0,0,0, 1,0,1,64'h100088,0,8'h00);
    vt[27] = mk(0,0,0,0,0, 0,0,0,0,0, 0,1,1,64'h1,0,8'hFF);
    vt[28] = mk(0,0,0,0,0, 0,0,0,0,0, 0,0,1,64'h1,7,8'h00);

    idle_in();
    repeat (2) @(negedge clk);
    chk("rst_pending", 64'(bus.cfg_commit_pending), 64'h0);
    chk("rst_mask", bus.patch_mask, 64'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_pending", 64'(bus.cfg_commit_pending), 64'h0);
    chk("reset_done", 64'(bus.cfg_commit_done), 64'h0);
    chk("reset_first", 64'(bus.patch_first_beat), 64'h1);
    chk("reset_mask", bus.patch_mask, 64'h0);
    chk("reset_data", 64'(bus.patch_data != '0), 64'h0);
    chk("reset_frames", 64'(bus.stat_frames), 64'h0);

    for (int i = 0; i < NV; i++) begin
      bus.cfg_wr_valid  = vt[i].wv;
      bus.cfg_wr_index  = vt[i].idx;
      bus.cfg_wr_offset = vt[i].off;
      bus.cfg_wr_data   = vt[i].dat;
      bus.cfg_wr_enable = vt[i].en;
      bus.cfg_clear     = vt[i].clr;
      bus.cfg_commit    = vt[i].cmt;
      bus.mon_tvalid    = vt[i].tv;
      bus.mon_tready    = vt[i].tr;
      bus.mon_tlast     = vt[i].tl;
      @(negedge clk);
      chk($sformatf("v%0d_pending", i),
          64'(bus.cfg_commit_pending), 64'(vt[i].e_pend));
      chk($sformatf("v%0d_done", i),
          64'(bus.cfg_commit_done), 64'(vt[i].e_done));
      chk($sformatf("v%0d_first", i),
          64'(bus.patch_first_beat), 64'(vt[i].e_first));
      chk($sformatf("v%0d_mask", i), bus.patch_mask, vt[i].e_mask);
      chk($sformatf("v%0d_byte%0d", i, vt[i].e_byte),
          64'(bus.patch_data[vt[i].e_byte*8 +: 8]), 64'(vt[i].e_bval));
    end
    idle_in();

    // reset in mid-frame with a commit pending
    bus.cfg_commit = 1'b1;
    bus.mon_tvalid = 1'b1;
    bus.mon_tready = 1'b1;
    @(negedge clk);
    idle_in();
    chk("mid_first_pre", 64'(bus.patch_first_beat), 64'h0);
    chk("mid_pending_pre", 64'(bus.cfg_commit_pending), 64'h1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_first", 64'(bus.patch_first_beat), 64'h1);
    chk("mid_rst_pending", 64'(bus.cfg_commit_pending), 64'h0);
    chk("mid_rst_mask", bus.patch_mask, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 4 frames (1, 2, 1, 3 beats) and 2 commits
    bus.cfg_commit = 1'b1;
    @(negedge clk);
    idle_in();
    @(negedge clk);
    beat(1'b1, 1'b1, "s_f1_b0_first");
    beat(1'b0, 1'b1, "s_f2_b0_first");
    beat(1'b1, 1'b0, "s_f2_b1_first");
    bus.cfg_commit = 1'b1;
    @(negedge clk);
    idle_in();
    @(negedge clk);
    beat(1'b1, 1'b1, "s_f3_b0_first");
    beat(1'b0, 1'b1, "s_f4_b0_first");
    beat(1'b0, 1'b0, "s_f4_b1_first");
    beat(1'b1, 1'b0, "s_f4_b2_first");
    chk("s_end_first", 64'(bus.patch_first_beat), 64'h1);
`ifdef KG_PATCH_STATS_EN
    chk("stat_frames", 64'(bus.stat_frames), 64'd4);
    chk("stat_commits", 64'(bus.stat_commits), 64'd2);
`else
    chk("stat_frames", 64'(bus.stat_frames), 64'd0);
    chk("stat_commits", 64'(bus.stat_commits), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/kugelblitz_patch_ctrl.md
Name: kugelblitz_patch_ctrl

Overview:
Per-port controller for the kugelblitz byte-substitution datapath. Holds a shadow table of up to ENTRY_COUNT (offset, value) patch entries, written from the AXI-lite register side. Commits the table atomically to an active byte mask/data vector, only at frame boundaries. Tracks AXIS frame state so the datapath patches the first beat of each frame only.

Parameters:
AXIS_ETH_DATA_WIDTH, 512, monitored stream data width.
AXIS_ETH_KEEP_WIDTH, AXIS_ETH_DATA_WIDTH/8, bytes per beat.
ENTRY_COUNT, 8, number of patch table entries.
OFFSET_WIDTH, $clog2(AXIS_ETH_KEEP_WIDTH), byte-offset field width (6).
COUNT_WIDTH, 32, statistics counter width.

Ports:
clk  in  1  single clock.
rst  in  1  asynchronous, active-high reset.
cfg_wr_valid  in  1  write one shadow entry this cycle.
cfg_wr_index  in  $clog2(ENTRY_COUNT)  entry index.
cfg_wr_offset  in  OFFSET_WIDTH  byte offset within first beat.
cfg_wr_data  in  8  replacement byte.
cfg_wr_enable  in  1  entry enable bit.
cfg_clear  in  1  clear all shadow enables.
cfg_commit  in  1  request shadow-to-active commit (pulse).
cfg_commit_pending  out  1  commit requested, not yet applied.
cfg_commit_done  out  1  one-cycle pulse when commit applied.
mon_tvalid / mon_tready / mon_tlast  in  1 each  monitored AXIS handshake.
patch_first_beat  out  1  current beat is first beat of a frame.
patch_mask  out  AXIS_ETH_KEEP_WIDTH  active per-byte substitute mask.
patch_data  out  AXIS_ETH_DATA_WIDTH  active per-byte substitute data.
stat_frames  out  COUNT_WIDTH  frames seen (stats build only).
stat_commits  out  COUNT_WIDTH  commits applied (stats build only).

Behaviour:
- Reset (async assert; deassert sampled on clk): shadow and active tables cleared, patch_mask=0, patch_data=0, cfg_commit_pending=0, cfg_commit_done=0, FSM=IDLE, stats=0.
- FSM IDLE (next beat is a first beat) / IN_FRAME.
  - IDLE -> IN_FRAME on mon_tvalid&mon_tready&!mon_tlast.
  - IN_FRAME -> IDLE on mon_tvalid&mon_tready&mon_tlast.
  - A single-beat frame stays in IDLE.
- patch_first_beat = (state==IDLE); combinational from state, no latency.
- Shadow writes take effect the next cycle.
  - cfg_clear together with cfg_wr_valid in the same cycle: clear first, then the write lands.
- cfg_commit sets pending the next cycle. A cfg_commit while already pending is absorbed, with no double commit.
- Commit instant is one of:
  - (a) pending & IDLE & !mon_tvalid;
  - (b) pending & tlast handshake this cycle.
- At the commit instant, patch_mask/patch_data are registered from the shadow, including any shadow write in that same cycle, which is forwarded. Outputs change on the next edge.
  - pending is cleared and cfg_commit_done pulses on that same edge.
- Writes issued after cfg_commit but before the commit instant are included in that commit.
- Decode: for each byte b, mask[b]=1 if any enabled entry has offset b. data[b] comes from the lowest-index matching enabled entry.
- The active outputs never change while IDLE & mon_tvalid & !mon_tready. This keeps the AXIS hold rule on the patched first beat.
- The datapath substitutes a byte only where patch_first_beat & patch_mask[b] & tkeep[b].
- A reset mid-frame returns the FSM to IDLE; the next beat is treated as a first beat.

Optional Feature:
KG_PATCH_STATS_EN:
- Defined: stat_frames increments on each tlast handshake and stat_commits on each commit; both wrap modulo 2^COUNT_WIDTH.
- Undefined: both outputs are tied to 0 and no counter flops are built.

Decomposition:
- Package kugelblitz_patch_pkg holds:
  - entry record typedef (enable, offset, data);
  - FSM state enum (IDLE, IN_FRAME);
  - default ENTRY_COUNT constant.
- One sub-module, kugelblitz_patch_decode: purely combinational entry table -> mask/data with lowest-index priority.

Test Plan:
- Basic commit: write entry0 (offset 12, 0x5A, en) and commit while idle with no traffic. Expect cfg_commit_done one cycle later, patch_mask=1<<12, patch_data byte12=0x5A, pending=0.
- Deferred commit: commit issued mid 3-beat frame. Expect pending=1 until the tlast handshake, outputs updated the following cycle, first beat of the next frame patched.
- Backpressure hold: commit pending, IDLE, mon_tvalid=1, mon_tready=0 for 5 cycles. Expect patch_mask unchanged and pending held until the frame's tlast.
- Priority: entry2 (offset 7, 0x11) and entry5 (offset 7, 0x22) both enabled, then commit. Expect byte7=0x11, mask bit7=1.
- Clear plus write in the same cycle: cfg_clear and a write of entry1 (offset 0, 0xFF), then commit. Expect mask=0x1 and data byte0=0xFF only.
- Stats (macro defined): 4 frames (1-beat, 2-beat, 1-beat, 3-beat) and 2 commits. Expect stat_frames=4, stat_commits=2. patch_first_beat is high on beat 0 of each frame only.
